// File: rtl/ppu_pkg.sv
// Shared PPU-side types and constants for the sprite DMA path.
// Holds the OAM DMA FSM states and the $4014 trigger address.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } oam_dma_state_t;

  localparam logic [15:0] OAM_DMA_REG_ADDR = 16'h4014;
  localparam int unsigned OAM_DMA_BYTES    = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: copies CPU page XX00-XXFF into OAM from OAMADDR.
// `define OAM_DMA_PARITY_ALIGN_EN adds the odd-cycle ALIGN stall.
module oam_dma_ctrl
  import ppu_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_REG_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic [7:0]  oam_addr_base,
  input  logic [7:0]  mem_data_in,
  output logic [15:0] mem_addr_out,
  output logic        mem_rd,
  output logic [7:0]  oam_addr_out,
  output logic [7:0]  oam_data_out,
  output logic        oam_WE,
  output logic        dma_active,
  output logic        dma_done
);

  oam_dma_state_t state, state_d;
  oam_dma_state_t halt_next;

  logic [7:0]  cnt, cnt_d, cnt_inc;
  logic [7:0]  page, page_d;
  logic [7:0]  base, base_d;
  logic [15:0] mem_addr_d;
  logic        mem_rd_d;
  logic [7:0]  oam_addr_d;
  logic [7:0]  oam_data_d;
  logic        oam_we_d;
  logic        active_d;
  logic        done_d;
  logic        trig;

  assign trig    = cpu_wr && (cpu_addr == DMA_REG_ADDR);
  assign cnt_inc = cnt + 8'd1;

`ifdef OAM_DMA_PARITY_ALIGN_EN
  logic parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (cpu_ce) begin
      parity <= ~parity;
    end
  end

  // Odd CPU cycle at HALT costs one extra cycle to line up reads.
  assign halt_next = parity ? ALIGN : READ;
`else
  assign halt_next = READ;
`endif

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    page_d     = page;
    base_d     = base;
    mem_addr_d = mem_addr_out;
    mem_rd_d   = mem_rd;
    oam_addr_d = oam_addr_out;
    oam_data_d = oam_data_out;
    oam_we_d   = 1'b0;
    active_d   = dma_active;
    done_d     = 1'b0;
    if (cpu_ce) begin
      unique case (state)
        IDLE: begin
          if (trig) begin
            page_d   = cpu_data_in;
            base_d   = oam_addr_base;
            cnt_d    = 8'd0;
            active_d = 1'b1;
            state_d  = HALT;
          end
        end
        HALT: begin
          state_d = halt_next;
          if (halt_next == READ) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = {page, cnt};
          end
        end
`ifdef OAM_DMA_PARITY_ALIGN_EN
        ALIGN: begin
          state_d    = READ;
          mem_rd_d   = 1'b1;
          mem_addr_d = {page, cnt};
        end
`endif
        READ: begin
          state_d  = WRITE;
          mem_rd_d = 1'b0;
        end
        WRITE: begin
          oam_data_d = mem_data_in;
          oam_addr_d = base + cnt;
          oam_we_d   = 1'b1;
          if (cnt == 8'hFF) begin
            done_d   = 1'b1;
            active_d = 1'b0;
            state_d  = IDLE;
          end else begin
            cnt_d      = cnt_inc;
            state_d    = READ;
            mem_rd_d   = 1'b1;
            mem_addr_d = {page, cnt_inc};
          end
        end
        default: begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          active_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      page         <= 8'd0;
      base         <= 8'd0;
      mem_addr_out <= 16'd0;
      mem_rd       <= 1'b0;
      oam_addr_out <= 8'd0;
      oam_data_out <= 8'd0;
      oam_WE       <= 1'b0;
      dma_active   <= 1'b0;
      dma_done     <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      page         <= page_d;
      base         <= base_d;
      mem_addr_out <= mem_addr_d;
      mem_rd       <= mem_rd_d;
      oam_addr_out <= oam_addr_d;
      oam_data_out <= oam_data_d;
      oam_WE       <= oam_we_d;
      dma_active   <= active_d;
      dma_done     <= done_d;
    end
  end

endmodule
